saw_wave_gen: RTL and testbench

SAW_WAVE_GEN -- requirements
Module: saw_wave

---
 rtl/saw_wave_gen.sv | 53 +++++
 tb/tb_saw_wave_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/saw_wave_gen.sv
// Sawtooth generator: unsigned W-bit ramp advancing once every DIV enabled clocks,
// with a one-cycle wrap pulse on the max-to-zero transition.
module saw_wave_gen #(
  parameter int N   = 8,
  parameter int DIV = 1,
  localparam int W  = $clog2(N-1) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  output logic [W-1:0] out,
  output logic         wrap
);

  localparam int PW = $clog2(DIV) + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [W-1:0]  CODE_MAX = '1;

  logic [PW-1:0] pre_cnt_p0;
  logic [W-1:0]  out_p0;
  logic          wrap_p0;
  logic          step;

  // Increment kept at W bits so the max code rolls over to zero by truncation.
  function automatic logic [W-1:0] ramp_inc(input logic [W-1:0] v);
    return v + 1'b1;
  endfunction

  assign step = ena && (pre_cnt_p0 == PRE_LAST);

  // Stage p0: prescaler, ramp code and wrap flag, all registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_p0 <= '0;
      out_p0     <= '0;
      wrap_p0    <= 1'b0;
    end else begin
      wrap_p0 <= step && (out_p0 == CODE_MAX);
      if (ena) begin
        if (step) begin
          pre_cnt_p0 <= '0;
          out_p0     <= ramp_inc(out_p0);
        end else begin
          pre_cnt_p0 <= pre_cnt_p0 + 1'b1;
        end
      end
    end
  end

  assign out  = out_p0;
  assign wrap = wrap_p0;

endmodule

// File: tb/tb_saw_wave_gen.sv
// Scoreboard bench for saw_wave_gen: three instances (N=8/DIV=1, N=8/DIV=3, N=16/DIV=1)
// driven by directed vectors; a monitor pops expected samples and compares them.
module tb_saw_wave_gen;

  logic       clk;
  logic       clk_run;
  logic       rst;
  logic       ena_a, ena_b, ena_c;
  logic [3:0] out_a, out_b;
  logic [4:0] out_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       chk_tog;

  typedef struct {
    int dut;
    int eo;
    bit ew;
    int tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   tag_n  = 0;

  saw_wave_gen #(.N(8),  .DIV(1)) dut_a (.clk(clk), .rst(rst), .ena(ena_a), .out(out_a), .wrap(wrap_a));
  saw_wave_gen #(.N(8),  .DIV(3)) dut_b (.clk(clk), .rst(rst), .ena(ena_b), .out(out_b), .wrap(wrap_b));
  saw_wave_gen #(.N(16), .DIV(1)) dut_c (.clk(clk), .rst(rst), .ena(ena_c), .out(out_c), .wrap(wrap_c));

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Monitor: drains the scoreboard at each falling edge or on an explicit async-check request.
  initial begin
    forever begin
      @(negedge clk or chk_tog);
      while (q.size() > 0) begin
        exp_t e;
        logic [5:0] ao;
        logic       aw;
        string      nm;
        e = q.pop_front();
        case (e.dut)
          0:       begin ao = {2'b00, out_a}; aw = wrap_a; nm = "n8_div1"; end
          1:       begin ao = {2'b00, out_b}; aw = wrap_b; nm = "n8_div3"; end
          default: begin ao = {1'b0, out_c};  aw = wrap_c; nm = "n16_div1"; end
        endcase
        checks++;
        if (ao !== 6'(e.eo) || aw !== e.ew) begin
          fails++;
          $display("FAIL %s #%0d: out=%0d wrap=%0b, expected out=%0d wrap=%0b",
                   nm, e.tag, ao, aw, e.eo, e.ew);
        end
      end
    end
  end

  task automatic expect_out(input int d, input int eo, input bit ew);
    exp_t e;
    e.dut = d; e.eo = eo; e.ew = ew; e.tag = tag_n;
    tag_n++;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; clk_run = 1'b0; chk_tog = 1'b0;
    rst = 1'b1; ena_a = 1'b0; ena_b = 1'b0; ena_c = 1'b0;

    // Reset with the clock stopped must clear everything immediately.
    #2 rst = 1'b0;
    #1;
    expect_out(0, 0, 0); expect_out(1, 0, 0); expect_out(2, 0, 0);
    chk_tog = ~chk_tog;
    #1 clk_run = 1'b1;

    // Reset dominates ena.
    ena_a = 1'b1;
    tick(); expect_out(0, 0, 0);
    tick(); expect_out(0, 0, 0);
    rst = 1'b1;

    // Free ramp through a wrap.
    for (int i = 1; i <= 20; i++) begin
      tick(); expect_out(0, i % 16, i == 16);
    end
    expect_out(1, 0, 0); expect_out(2, 0, 0);
    for (int i = 5; i <= 7; i++) begin
      tick(); expect_out(0, i, 0);
    end

    // Hold at 7, then resume with 8.
    ena_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); expect_out(0, 7, 0);
    end
    ena_a = 1'b1;
    tick(); expect_out(0, 8, 0);
    for (int i = 9; i <= 15; i++) begin
      tick(); expect_out(0, i, 0);
    end

    // Hold at max: no wrap pulse; then wrap; then hold at zero: no pulse.
    ena_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out(0, 15, 0);
    end
    ena_a = 1'b1;
    tick(); expect_out(0, 0, 1);
    ena_a = 1'b0;
    tick(); expect_out(0, 0, 0);
    tick(); expect_out(0, 0, 0);
    ena_a = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick(); expect_out(0, i, 0);
    end

    // Asynchronous reset pulse between edges while out=9.
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    expect_out(0, 0, 0); expect_out(1, 0, 0); expect_out(2, 0, 0);
    chk_tog = ~chk_tog;
    #1 rst = 1'b1;
    tick(); expect_out(0, 1, 0);
    tick(); expect_out(0, 2, 0);
    ena_a = 1'b0;

    // DIV=3: one step every three enabled edges.
    ena_b = 1'b1;
    tick(); expect_out(1, 0, 0);
    tick(); expect_out(1, 0, 0);
    tick(); expect_out(1, 1, 0);
    tick(); expect_out(1, 1, 0);
    tick(); expect_out(1, 1, 0);
    tick(); expect_out(1, 2, 0);
    tick(); expect_out(1, 2, 0);
    // Pause with one enabled edge already counted; two more must suffice afterwards.
    ena_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out(1, 2, 0);
    end
    ena_b = 1'b1;
    tick(); expect_out(1, 2, 0);
    tick(); expect_out(1, 3, 0);
    for (int k = 1; k <= 42; k++) begin
      tick(); expect_out(1, (3 + k / 3) % 16, k == 39);
    end
    ena_b = 1'b0;
    expect_out(0, 2, 0);

    // N=16: five-bit ramp wraps after 31.
    ena_c = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      tick(); expect_out(2, i % 32, i == 32);
    end
    ena_c = 1'b0;
    tick(); expect_out(2, 2, 0); expect_out(1, 1, 0);

    tick();
    tick();
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
